// File: rtl/dcache_preloader.sv
// Streams bytes into 32-bit little-endian words, writes each word into the D-cache
// and reads it back one cycle later, flagging any readback mismatch.
module dcache_preloader #(
  parameter int DPW  = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            start,
  input  logic [DPW-1:0]  base_addr,
  input  logic [CNTW-1:0] word_count,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  output logic            s_ready,
  output logic            data_en,
  output logic [DPW-1:0]  input_addr,
  output logic [DPW-1:0]  input_data,
  input  logic [DPW-1:0]  output_check,
  output logic            busy,
  output logic            done,
  output logic            err_mismatch,
  output logic [CNTW-1:0] words_written,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [DPW-1:0]  base_q, base_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] words_q, words_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     buf_q, buf_d;
  logic [DPW-1:0]  addr_q, addr_d;
  logic [DPW-1:0]  data_q, data_d;
  logic            err_q, err_d;

  // Handshake: a byte transfers on a rising edge where s_valid and s_ready are both high.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    words_d    = words_q;
    byte_cnt_d = byte_cnt_q;
    buf_d      = buf_q;
    addr_d     = addr_q;
    data_d     = data_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          words_d    = '0;
          err_d      = 1'b0;
          byte_cnt_d = 2'd0;
          if (word_count != '0) begin
            base_d  = base_addr;
            count_d = word_count;
            state_d = COLLECT;
          end else begin
            state_d = DONE;
          end
        end
      end
      COLLECT: begin
        if (s_valid) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: buf_d[7:0]   = s_data;
            2'd1: buf_d[15:8]  = s_data;
            2'd2: buf_d[23:16] = s_data;
            default: begin
              data_d  = DPW'({s_data, buf_q});
              addr_d  = base_q + (DPW'(words_q) << 2);
              state_d = WRITE;
            end
          endcase
        end
      end
      WRITE: state_d = CHECK;
      CHECK: begin
        if (output_check != data_q) err_d = 1'b1;
        words_d = words_q + CNTW'(1);
        state_d = (words_q + CNTW'(1) == count_q) ? DONE : COLLECT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      words_q    <= '0;
      byte_cnt_q <= 2'd0;
      buf_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      words_q    <= words_d;
      byte_cnt_q <= byte_cnt_d;
      buf_q      <= buf_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign s_ready       = (state_q == COLLECT);
  assign data_en       = (state_q == WRITE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign input_addr    = addr_q;
  assign input_data    = data_q;
  assign err_mismatch  = err_q;
  assign words_written = words_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dcache_preloader.sv
// Bench for dcache_preloader: table of loads plus hand-written reset / zero-count sequences.
module tb_dcache_preloader;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_count = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, data_en, busy, done, err_mismatch;
  logic [31:0] input_addr, input_data, output_check;
  logic [15:0] words_written;
  logic [2:0]  dbg_state;

  dcache_preloader #(.DPW(32), .CNTW(16)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .data_en(data_en), .input_addr(input_addr), .input_data(input_data),
    .output_check(output_check), .busy(busy), .done(done),
    .err_mismatch(err_mismatch), .words_written(words_written), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Memory model: remembers the last write, optionally corrupts address 0x104.
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  bit          bad_en = 1'b0;
  always @(posedge clk) if (data_en) begin
    last_addr <= input_addr;
    last_data <= input_data;
  end
  assign output_check = (bad_en && input_addr == 32'h104) ? 32'hDEADBEEF :
                        (input_addr == last_addr) ? last_data : 32'h0;

  // Scoreboard
  int n_checks = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];
  int we_cnt = 0;
  int done_cnt = 0;
  logic err_at_done = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  always @(negedge clk) if (arst_n) begin
    if (data_en) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("unexpected_write", {input_addr, input_data}, 64'h0);
      else chk("write", {input_addr, input_data}, exp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      err_at_done = err_mismatch;
    end
  end

  typedef struct {
    logic [31:0] base;
    logic [15:0] count;
    logic [63:0] bytes;
    bit          gap;
    bit          restart;
    bit          bad;
    bit          exp_err;
  } vec_t;
  vec_t vecs[5];

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int cnt = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while (busy && cnt < 50) begin
      tick();
      cnt++;
    end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic run_load(input vec_t v);
    bad_en   = v.bad;
    done_cnt = 0;
    we_cnt   = 0;
    pulse_start(v.base, v.count);
    chk("start_clears_err", err_mismatch, 0);
    chk("start_clears_words", words_written, 0);
    for (int w = 0; w < v.count; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 3) exp_q.push_back({v.base + 32'(w * 4), v.bytes[32*w +: 32]});
        send_byte(v.bytes[8*(4*w+b) +: 8]);
        if (w == 0 && b == 1 && v.gap) begin
          for (int g = 0; g < 3; g++) begin
            chk("gap_ready", {s_ready, data_en}, 2'b10);
            tick();
          end
        end
        if (w == 0 && b == 1 && v.restart) pulse_start(32'h500, 16'd1);
      end
      chk("latency_we", data_en, 1);
      tick();
      chk("check_no_we", {data_en, busy}, 2'b01);
    end
    wait_idle();
    chk("words_written", words_written, v.count);
    chk("err_final", err_mismatch, v.exp_err);
    chk("err_at_done", err_at_done, v.exp_err);
    chk("done_pulses", done_cnt, 1);
    chk("we_count", we_cnt, v.count);
    chk("queue_empty", exp_q.size(), 0);
    bad_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h100, 16'd2, 64'h8877665544332211, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h100, 16'd2, 64'h8877665544332211, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h100, 16'd2, 64'h8877665544332211, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{32'hFFFFFFFC, 16'd2, 64'h0102030405060708, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{{22'($urandom_range(0, 4000)), 10'h0}, 16'd2, {$urandom, $urandom},
                1'b1, 1'b0, 1'b0, 1'b0};

    repeat (3) tick();
    arst_n = 1'b1;
    chk("reset_outputs", {s_ready, data_en, busy, done, err_mismatch, words_written}, 64'h0);
    chk("reset_addr_data", {input_addr, input_data}, 64'h0);

    // Zero-count load: done one cycle later, busy for exactly one cycle.
    we_cnt = 0;
    pulse_start(32'h40, 16'd0);
    chk("zero_done", {done, busy, data_en}, 3'b110);
    tick();
    chk("zero_idle", {done, busy, data_en, words_written}, 19'h0);
    chk("zero_no_we", we_cnt, 0);

    for (int i = 0; i < 5; i++) run_load(vecs[i]);

    // Reset in the middle of a load, then a fresh single-word load.
    we_cnt = 0;
    pulse_start(32'h300, 16'd2);
    send_byte(8'h12);
    send_byte(8'h34);
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    chk("midreset_outputs", {s_ready, data_en, busy, done, err_mismatch, words_written}, 64'h0);
    chk("midreset_addr_data", {input_addr, input_data}, 64'h0);
    repeat (4) tick();
    chk("midreset_no_we", we_cnt, 0);
    run_load('{32'h200, 16'd1, 64'hDDCCBBAA, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
